// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and constants for the SIPO frame receiver
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

  localparam logic START_LEVEL = 1'b1;

endpackage

// File: rtl/sipo_shift_en.sv
// rtl/sipo_shift_en.sv - N-bit serial-in/parallel-out register with shift enable
module sipo_shift_en #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         serial_in,
  output logic [N-1:0] q_next
);

  logic [N-1:0] q;

  // Exposes the value the register takes at the coming edge, so the last
  // data bit can be captured into the holding register on the same edge.
  always_comb begin
    q_next = q;
    if (shift_en) begin
      q_next = {q[N-2:0], serial_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// rtl/sipo_rx_ctrl.sv - framed serial word receiver; SIPO_RX_PARITY_EN adds an even-parity bit
module sipo_rx_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         serial_in,
  input  logic         out_ready,
  input  logic         ovr_clr,
  output logic [N-1:0] data_out,
  output logic         out_valid,
  output logic         busy,
  output logic         overrun,
  output logic         parity_err
);

  import sipo_pkg::*;

  localparam int CNT_W = $clog2(N);

  rx_state_t        state_q;
  rx_state_t        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             complete;
  logic             shift_en;
  logic             drop;
  logic [N-1:0]     word;

  assign shift_en = enable && (state_q == SHIFT);
  assign busy     = (state_q != IDLE);
  assign drop     = complete && out_valid && !out_ready;

  sipo_shift_en #(.N(N)) u_shift (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .serial_in (serial_in),
    .q_next    (word)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (serial_in == START_LEVEL) begin
            state_d = SHIFT;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          if (cnt_q == CNT_W'(N - 1)) begin
            cnt_d = '0;
`ifdef SIPO_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d  = IDLE;
            complete = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef SIPO_RX_PARITY_EN
        PARITY: begin
          state_d  = IDLE;
          complete = 1'b1;
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A completed word is dropped only when the previous one is still pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else if (complete && !drop) begin
      data_out  <= word;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

`ifdef SIPO_RX_PARITY_EN
  logic par_q;

  // In PARITY the register is not shifting, so word is the full data word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (complete && !drop) begin
      par_q <= (^word) ^ serial_in;
    end
  end

  assign parity_err = par_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/sipo_rx_ctrl.md
Name: sipo_rx_ctrl

Overview:
Controller that sequences a serial-in/parallel-out shift register to deserialize framed serial words. Each frame is a start bit, N data bits sent MSB-first, and an optional parity bit.
- Detects the start bit and enables shifting for exactly N cycles.
- Moves the completed word into a holding register and presents it with a valid/ready handshake.
- Sits between a serial line/pin interface and the parallel consumer logic.

Parameters:
N, 4, data word width in bits (N >= 2).
CNT_W, $clog2(N), width of the bit counter (localparam, derived).

Ports:
clk  input  1  system clock, all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  1 = receiver armed; 0 = return to IDLE and discard any partial frame.
serial_in  input  1  serial data, sampled on posedge clk.
out_ready  input  1  consumer accepts data_out when out_valid && out_ready.
ovr_clr  input  1  synchronous clear of overrun.
data_out  output  N  held received word; first data bit received is in data_out[N-1].
out_valid  output  1  data_out holds an unconsumed word.
busy  output  1  frame in progress (state != IDLE).
overrun  output  1  sticky flag: a word completed while the previous word was still unconsumed.
parity_err  output  1  parity result for the word currently in data_out.

Behaviour:
- Reset (async): state=IDLE, bit counter=0, shift register=0, data_out=0, out_valid=0, overrun=0, parity_err=0, busy=0.

States:
- IDLE:
  - If enable && serial_in==1 at a posedge, that edge samples the start bit.
  - Go to SHIFT with counter=0.
- SHIFT:
  - Each posedge shifts serial_in into the shift register at the LSB side.
  - Counter increments each posedge.
  - On the edge that samples the N-th data bit (counter==N-1), go to PARITY if PARITY_EN is defined; otherwise complete the word and return to IDLE.
- PARITY (only when compiled in): sample the parity bit, complete the word, return to IDLE.

Word completion and latency:
- Start bit is sampled at edge k; data bits are sampled at edges k+1..k+N.
- Without parity, out_valid=1 and data_out are visible after edge k+N.
- With parity, they are visible after edge k+N+1.
- A new start bit may be accepted on the edge immediately after completion, i.e. back-to-back frames with no idle gap.

Handshake:
- out_valid falls after any edge where out_valid && out_ready.
- data_out stays stable while out_valid=1 and is not consumed.
- Completion while out_valid=1 and out_ready=0: the new word is dropped, data_out is unchanged, overrun is set to 1.
- Completion in the same cycle as consumption (out_valid && out_ready): the new word is loaded, out_valid stays 1, no overrun.

Overrun clearing:
- ovr_clr=1 clears overrun on the next edge.
- If ovr_clr and a new overrun occur in the same cycle, set wins.

enable deasserted mid-frame:
- The next edge returns to IDLE with counter=0 and the partial word discarded.
- out_valid and data_out are unaffected.

Other:
- Reset asserted mid-frame or mid-handshake: all state returns to reset values immediately.
- busy = (state != IDLE), registered state decode.

Optional Feature:
- Macro: SIPO_RX_PARITY_EN.
- Defined:
  - PARITY state is present; one extra bit is sampled per frame.
  - Even parity: parity_err = XOR of the N data bits and the parity bit.
  - parity_err is loaded together with data_out, so it is dropped on overrun along with the word.
- Undefined:
  - No PARITY state; frame = start bit + N data bits.
  - parity_err is tied to 0.

Decomposition:
- Shared package sipo_pkg:
  - state enum type rx_state_t (IDLE, SHIFT, PARITY);
  - localparam START_LEVEL = 1'b1.
- One natural sub-module: sipo_shift_en, an N-bit SIPO register with a shift_en input and the same clk/rst conventions.
  - Instantiated once, driven by the FSM.
- The FSM, counter, holding register and flags stay in sipo_rx_ctrl.

Test Plan (N=4 unless noted):
1. Reset then enable=1; serial_in 1 (start), then 1,0,1,1 → after the 5th edge, data_out=4'b1011, out_valid=1, busy=0. out_ready pulse → out_valid=0.
2. Two back-to-back frames, 1011 then 0110, with out_ready held 1 → out_valid rises twice, data_out=1011 then 0110, overrun=0.
3. Frame 1011 left unconsumed, then frame 0001 → data_out stays 1011, overrun=1. ovr_clr pulse → overrun=0.
4. Start bit, then 1,0 followed by enable=0 → busy=0 on the next edge, out_valid=0. A later full frame 1100 → data_out=1100.
5. rst asserted mid-frame between edges → all outputs 0 immediately, without waiting for a clock edge. After release, frame 0101 is received correctly.
6. SIPO_RX_PARITY_EN defined: frame 1011 with parity bit 1 → parity_err=0, data valid after 6 edges. Frame 1011 with parity bit 0 → parity_err=1.
